// File: rtl/fp_wire.sv
// fp_wire: shared types and constants for the rounding/packing pipeline
package fp_wire;
  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  typedef enum logic [2:0] {SP_NORM, SP_NV, SP_QNAN, SP_DBZ, SP_INF, SP_ZERO} spec_t;
  typedef struct packed {
    logic sig;
    logic [10:0] expo;
    logic [24:0] mant;
    logic [1:0] rema;
    logic [1:0] fmt;
    logic [2:0] rm;
    logic [2:0] grs;
    logic snan;
    logic qnan;
    logic dbz;
    logic inf;
    logic zero;
    logic diff;
    logic ready;
  } fp_rnd_in_type;
  typedef struct packed {
    logic [31:0] result;
    logic [4:0] flags;
    logic ready;
  } fp_rnd_out_type;
  typedef struct packed {
    logic sig;
    logic [10:0] expo;
    logic [24:0] m;
    logic inc;
    logic inexact;
    logic [2:0] rm;
    spec_t spec;
    logic ready;
  } fp_rnd_reg_type_1;
  typedef struct packed {
    logic [31:0] result;
    logic [4:0] flags;
    logic ready;
  } fp_rnd_reg_type_2;
  localparam fp_rnd_reg_type_1 init_fp_rnd_reg_1 = '{sig: 1'b0, expo: 11'd0, m: 25'd0, inc: 1'b0,
    inexact: 1'b0, rm: 3'd0, spec: SP_NORM, ready: 1'b0};
  localparam fp_rnd_reg_type_2 init_fp_rnd_reg_2 = '{result: 32'd0, flags: 5'd0, ready: 1'b0};
endpackage

// File: rtl/fp_rnd_pipe_inc.sv
// fp_rnd_inc: round-increment and inexact decision from guard/round/sticky bits
module fp_rnd_inc
  import fp_wire::*;
(
  input  logic [2:0] rm,
  input  logic       sig,
  input  logic [2:0] grs,
  input  logic [1:0] rema,
  input  logic       lsb,
  output logic       inc,
  output logic       inexact
);
  logic s;
  assign s = grs[0] | (|rema);
  assign inexact = grs[2] | grs[1] | s;
  // unlisted mode codes fall through to round-to-nearest-even
  always_comb
    inc = rm == RTZ ? 1'b0 :
          rm == RDN ? sig & inexact :
          rm == RUP ? ~sig & inexact :
          rm == RMM ? grs[2] :
          grs[2] & (grs[1] | s | lsb);
endmodule

// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage single-precision rounding, packing and flag generation
module fp_rnd_pipe
  import fp_wire::*;
(
  input  logic           clock,
  input  logic           reset,
  input  fp_rnd_in_type  fp_rnd_i,
  output fp_rnd_out_type fp_rnd_o
);
  fp_rnd_reg_type_1 r1, n1;
  fp_rnd_reg_type_2 r2;
  logic inc, inexact, carry, of, uf, max_fin;
  logic [23:0] m_sh;
  logic [11:0] e;
  logic [31:0] res;
  logic [4:0] flg;
  fp_rnd_inc u_inc (
    .rm(fp_rnd_i.rm),
    .sig(fp_rnd_i.sig),
    .grs(fp_rnd_i.grs),
    .rema(fp_rnd_i.rema),
    .lsb(fp_rnd_i.mant[0]),
    .inc(inc),
    .inexact(inexact)
  );
  // stage 1: round the mantissa and classify specials; idle cycles load the init value
  always_comb begin
    n1 = init_fp_rnd_reg_1;
    if (fp_rnd_i.ready) begin
      n1.expo = fp_rnd_i.expo;
      n1.m = fp_rnd_i.mant + {24'd0, inc};
      n1.inc = inc;
      n1.inexact = inexact;
      n1.rm = fp_rnd_i.rm;
      n1.spec = (fp_rnd_i.fmt != 2'd0 || fp_rnd_i.snan) ? SP_NV :
                fp_rnd_i.qnan ? SP_QNAN :
                fp_rnd_i.dbz ? SP_DBZ :
                fp_rnd_i.inf ? SP_INF :
                fp_rnd_i.zero ? SP_ZERO : SP_NORM;
      n1.sig = (n1.spec == SP_ZERO && fp_rnd_i.diff) ? fp_rnd_i.rm == RDN : fp_rnd_i.sig;
      n1.ready = 1'b1;
    end
  end
  // stage 1 register
  always_ff @(posedge clock)
    r1 <= !reset ? init_fp_rnd_reg_1 : n1;
  // stage 2: carry renormalisation, exponent fix-up, overflow/underflow and packing
  always_comb begin
    carry = r1.m[24] & r1.inc;
    m_sh = carry ? r1.m[24:1] : r1.m[23:0];
    e = (r1.expo == 11'd0 && m_sh[23]) ? 12'd1 : {1'b0, r1.expo} + {11'd0, carry};
    of = e >= 12'd255;
    uf = e == 12'd0 && r1.inexact;
    max_fin = r1.rm == RTZ || (r1.rm == RDN && !r1.sig) || (r1.rm == RUP && r1.sig);
    res = (r1.spec == SP_NV || r1.spec == SP_QNAN) ? CANON_NAN :
          (r1.spec == SP_DBZ || r1.spec == SP_INF) ? {r1.sig, 8'hFF, 23'd0} :
          r1.spec == SP_ZERO ? {r1.sig, 31'd0} :
          of ? (max_fin ? {r1.sig, 31'h7F7FFFFF} : {r1.sig, 8'hFF, 23'd0}) :
          {r1.sig, e[7:0], m_sh[22:0]};
    flg = r1.spec == SP_NV ? 5'b10000 :
          r1.spec == SP_DBZ ? 5'b01000 :
          r1.spec == SP_NORM ? {2'b00, of, uf, of | r1.inexact} : 5'b00000;
  end
  // output register: result and flags hold between operations, ready pulses
  always_ff @(posedge clock)
    if (!reset) r2 <= init_fp_rnd_reg_2;
    else if (r1.ready) r2 <= '{result: res, flags: flg, ready: 1'b1};
    else r2.ready <= 1'b0;
  assign fp_rnd_o = '{result: r2.result, flags: r2.flags, ready: r2.ready};
endmodule

// File: tb/tb_fp_rnd_pipe.sv
// tb_fp_rnd_pipe: scoreboard bench with directed cases and a behavioural rounding model
module tb_fp_rnd_pipe;
  import fp_wire::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  fp_rnd_in_type fp_rnd_i = '0;
  fp_rnd_out_type fp_rnd_o;
  logic [36:0] q[$];
  int vectors = 0, miscompares = 0, run = 0, max_run = 0;

  fp_rnd_pipe dut (.clock(clock), .reset(reset), .fp_rnd_i(fp_rnd_i), .fp_rnd_o(fp_rnd_o));

  always #5 clock = ~clock;

  function automatic logic [36:0] model(fp_rnd_in_type x);
    logic s, g, r, nx, up;
    int md, m, e;
    if (x.fmt != 0 || x.snan) return {32'h7FC00000, 5'h10};
    if (x.qnan) return {32'h7FC00000, 5'h00};
    if (x.dbz) return {x.sig, 31'h7F800000, 5'h08};
    if (x.inf) return {x.sig, 31'h7F800000, 5'h00};
    if (x.zero) return {(x.diff ? (x.rm == 3'd2) : x.sig), 31'h0, 5'h00};
    g = x.grs[2];
    r = x.grs[1];
    s = x.grs[0] || x.rema != 0;
    nx = g || r || s;
    md = x.rm > 4 ? 0 : int'(x.rm);
    case (md)
      0: up = g && (r || s || x.mant[0]);
      1: up = 1'b0;
      2: up = x.sig && nx;
      3: up = !x.sig && nx;
      default: up = g;
    endcase
    m = int'(x.mant) + int'(up);
    e = int'(x.expo);
    if (m >= 32'h1000000) begin
      m = m / 2;
      e = e + 1;
    end
    if (x.expo == 0 && m >= 32'h800000) e = 1;
    if (e >= 255)
      return {((md == 1 || (md == 2 && !x.sig) || (md == 3 && x.sig)) ?
               {x.sig, 31'h7F7FFFFF} : {x.sig, 31'h7F800000}), 5'b00101};
    return {x.sig, 8'(e), 23'(m), 3'b000, (e == 0 && nx), nx};
  endfunction

  function automatic fp_rnd_in_type mk(int ex, int mn, logic [2:0] g, logic [2:0] rm, logic s);
    fp_rnd_in_type x;
    x = '0;
    x.expo = 11'(ex);
    x.mant = 25'(mn);
    x.grs = g;
    x.rm = rm;
    x.sig = s;
    x.ready = 1'b1;
    return x;
  endfunction

  function automatic fp_rnd_in_type rnd();
    fp_rnd_in_type x;
    x = '0;
    x.sig = 1'($urandom);
    x.expo = $urandom_range(0, 3) == 0 ? 11'($urandom_range(0, 2)) :
             $urandom_range(0, 3) == 0 ? 11'($urandom_range(250, 260)) : 11'($urandom_range(1, 254));
    x.mant = {1'b0, x.expo != 0, 23'($urandom)};
    if ($urandom_range(0, 5) == 0) x.mant[22:0] = '1;
    x.rema = 2'($urandom);
    x.grs = 3'($urandom);
    x.rm = 3'($urandom);
    x.fmt = $urandom_range(0, 15) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
    x.snan = $urandom_range(0, 15) == 0;
    x.qnan = $urandom_range(0, 15) == 0;
    x.dbz = $urandom_range(0, 15) == 0;
    x.inf = $urandom_range(0, 15) == 0;
    x.zero = $urandom_range(0, 15) == 0;
    x.diff = 1'($urandom);
    x.ready = 1'b1;
    return x;
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  task automatic drive(fp_rnd_in_type x, logic [36:0] req);
    @(negedge clock);
    fp_rnd_i = x;
    if (x.ready) q.push_back(req);
  endtask

  task automatic idle(int n);
    fp_rnd_in_type x;
    for (int i = 0; i < n; i++) begin
      x = rnd();
      x.ready = 1'b0;
      drive(x, '0);
    end
  endtask

  always @(negedge clock) begin
    logic [36:0] req;
    run = fp_rnd_o.ready ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (fp_rnd_o.ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_ready result=%h flags=%h required=no_ready", fp_rnd_o.result, fp_rnd_o.flags);
      end else begin
        req = q.pop_front();
        if ({fp_rnd_o.result, fp_rnd_o.flags} !== req) begin
          miscompares++;
          $display("FAIL result_flags actual=%h/%h required=%h/%h",
                   fp_rnd_o.result, fp_rnd_o.flags, req[36:5], req[4:0]);
        end
      end
    end
  end

  initial begin
    fp_rnd_in_type x;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ready", fp_rnd_o.ready, 0);
    chk("reset_result", fp_rnd_o.result, 0);
    chk("reset_flags", fp_rnd_o.flags, 0);
    @(negedge clock);
    reset = 1'b1;
    drive(mk(127, 'h0800000, 3'b000, RNE, 0), {32'h3F800000, 5'h00});
    drive(mk(127, 'h0800001, 3'b100, RNE, 0), {32'h3F800002, 5'h01});
    drive(mk(127, 'h0800000, 3'b100, RNE, 0), {32'h3F800000, 5'h01});
    drive(mk(127, 'h0FFFFFF, 3'b110, RNE, 0), {32'h40000000, 5'h01});
    drive(mk(255, 'h0800000, 3'b000, RNE, 0), {32'h7F800000, 5'h05});
    drive(mk(255, 'h0800000, 3'b000, RTZ, 0), {32'h7F7FFFFF, 5'h05});
    drive(mk(255, 'h0800000, 3'b000, RDN, 1), {32'hFF800000, 5'h05});
    drive(mk(255, 'h0800000, 3'b000, RDN, 0), {32'h7F7FFFFF, 5'h05});
    drive(mk(0, 'h0000001, 3'b010, RUP, 0), {32'h00000002, 5'h03});
    drive(mk(0, 'h07FFFFF, 3'b100, RNE, 0), {32'h00800000, 5'h01});
    drive(mk(127, 'h0800001, 3'b100, 3'd6, 0), {32'h3F800002, 5'h01});
    x = mk(127, 'h0800000, 0, RNE, 0); x.snan = 1; x.qnan = 1;
    drive(x, {32'h7FC00000, 5'h10});
    x = mk(127, 'h0800000, 0, RNE, 0); x.fmt = 2'd1;
    drive(x, {32'h7FC00000, 5'h10});
    x = mk(127, 'h0800000, 0, RNE, 0); x.qnan = 1; x.dbz = 1;
    drive(x, {32'h7FC00000, 5'h00});
    x = mk(127, 'h0800000, 3'b111, RNE, 1); x.dbz = 1;
    drive(x, {32'hFF800000, 5'h08});
    x = mk(127, 'h0800000, 3'b111, RNE, 0); x.inf = 1; x.zero = 1;
    drive(x, {32'h7F800000, 5'h00});
    x = mk(0, 0, 0, RDN, 0); x.zero = 1; x.diff = 1;
    drive(x, {32'h80000000, 5'h00});
    x = mk(0, 0, 0, RNE, 1); x.zero = 1; x.diff = 1;
    drive(x, {32'h00000000, 5'h00});
    x = mk(0, 0, 0, RNE, 1); x.zero = 1;
    drive(x, {32'h80000000, 5'h00});
    idle(3);
    for (int i = 0; i < 3; i++) begin
      x = rnd();
      drive(x, model(x));
    end
    @(negedge clock);
    reset = 1'b0;
    fp_rnd_i.ready = 1'b0;
    @(posedge clock);
    q.delete();
    #1;
    chk("flush_ready", fp_rnd_o.ready, 0);
    chk("flush_result", fp_rnd_o.result, 0);
    chk("flush_flags", fp_rnd_o.flags, 0);
    @(negedge clock);
    reset = 1'b1;
    idle(4);
    for (int i = 0; i < 400; i++) begin
      x = rnd();
      if ($urandom_range(0, 7) == 0) x.ready = 1'b0;
      drive(x, model(x));
    end
    idle(1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
    chk("drain", q.size(), 0);
    chk("burst_run", max_run >= 8, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
